// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// The optional overflow output is enabled by SERIAL_SUBTRACTOR_OVF_EN.
package serial_subtractor_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_SHIFT = 2'd1;
    localparam logic [1:0] ENC_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ENC_IDLE,
        SHIFT = ENC_SHIFT,
        DONE  = ENC_DONE
    } state_t;

    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, valid/ready on both sides.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed overflow output o_overflow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             o_overflow
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             d;
    logic             bout;
    logic [WIDTH-1:0] nxt_a;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    full_subtractor_bit u_fs (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .bin (brw),
        .d   (d),
        .bout(bout)
    );

    assign o_ready = (state == IDLE);

    // A's register doubles as the result register: each consumed LSB
    // frees the MSB slot that receives the new difference bit.
    assign nxt_a = {d, a_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            cnt      <= '0;
            brw      <= 1'b0;
            o_valid  <= 1'b0;
            o_diff   <= '0;
            o_borrow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            o_overflow <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_sr  <= i_minuend;
                        b_sr  <= i_subtrahend;
                        brw   <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        a_msb <= i_minuend[WIDTH-1];
                        b_msb <= i_subtrahend[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sr <= nxt_a;
                    b_sr <= b_sr >> 1;
                    brw  <= bout;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= DONE;
                        o_valid  <= 1'b1;
                        o_diff   <= nxt_a;
                        o_borrow <= bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        o_overflow <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8).
// Overflow checks build when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_minuend;
    logic [WIDTH-1:0] i_subtrahend;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             o_overflow;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             br;
        logic             ov;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_minuend   (i_minuend),
        .i_subtrahend(i_subtrahend),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_diff      (o_diff),
        .o_borrow    (o_borrow)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .o_overflow  (o_overflow)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        exp_t e;
        e.d  = a - b;
        e.br = (a < b);
        e.ov = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ e.d[WIDTH-1]);
        return e;
    endfunction

    // Drives one operand pair; pushes the expectation on the accept edge.
    task automatic issue(input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b,
                         output bit ok, output logic busy);
        ok   = 1'b0;
        busy = 1'b0;
        @(negedge clk);
        i_valid      = 1'b1;
        i_minuend    = a;
        i_subtrahend = b;
        for (int k = 0; k < 300; k++) begin
            if (o_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            busy = o_valid;
            @(posedge clk);
            sbq.push_back(model(a, b));
            #1;
        end
        i_valid      = 1'b0;
        i_minuend    = WIDTH'($urandom);
        i_subtrahend = WIDTH'($urandom);
    endtask

    task automatic wait_res(output bit got);
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic handoff();
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", o_ready);
        end
        n_cmp++;
        if ({o_valid, o_borrow, o_diff} !== '0) begin
            n_bad++;
            $display("FAIL reset_outs: got v=%b b=%b d=%h want 0",
                     o_valid, o_borrow, o_diff);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset: got rdy=%b v=%b want 1/0",
                     o_ready, o_valid);
        end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] ta[4] = '{8'd10, 8'd3, 8'h00, 8'hFF};
        logic [WIDTH-1:0] tb[4] = '{8'd3, 8'd10, 8'h00, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            bit   ok;
            logic busy;
            int   lat;
            exp_t e;
            issue(ta[i], tb[i], ok, busy);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL basic_accept[%0d]: got no accept want accept", i);
                continue;
            end
            lat = 0;
            for (int k = 1; k <= 100; k++) begin
                @(posedge clk);
                #1;
                if (o_valid) begin
                    lat = k;
                    break;
                end
            end
            n_cmp++;
            if (lat != WIDTH) begin
                n_bad++;
                $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, WIDTH);
            end
            e = sbq.pop_front();
            n_cmp++;
            if (o_diff !== e.d || o_borrow !== e.br) begin
                n_bad++;
                $display("FAIL basic_result[%0d]: got %h/%b want %h/%b",
                         i, o_diff, o_borrow, e.d, e.br);
            end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            n_cmp++;
            if (o_overflow !== e.ov) begin
                n_bad++;
                $display("FAIL basic_ovf[%0d]: got %b want %b", i, o_overflow, e.ov);
            end
`endif
            handoff();
        end
    endtask

    task automatic test_backpressure();
        bit   ok;
        bit   got;
        logic busy;
        exp_t e;
        issue(8'h55, 8'h0F, ok, busy);
        wait_res(got);
        n_cmp++;
        if (!ok || !got || sbq.size() == 0) begin
            n_bad++;
            $display("FAIL bp_result: got ok=%b got=%b want 1/1", ok, got);
            sbq.delete();
            return;
        end
        e = sbq.pop_front();
        i_valid      = 1'b1;
        i_minuend    = 8'h33;
        i_subtrahend = 8'h11;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (o_valid !== 1'b1 || o_diff !== e.d || o_borrow !== e.br ||
                o_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h b=%b r=%b want 1/%h/%b/0",
                         k, o_valid, o_diff, o_borrow, o_ready, e.d, e.br);
            end
            @(negedge clk);
        end
        handoff();
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_diff !== e.d) begin
            n_bad++;
            $display("FAIL bp_handoff: got v=%b r=%b d=%h want 0/1/%h",
                     o_valid, o_ready, o_diff, e.d);
        end
        @(posedge clk);
        sbq.push_back(model(8'h33, 8'h11));
        #1;
        i_valid = 1'b0;
        n_cmp++;
        if (o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_late_accept: got rdy=%b want 0", o_ready);
        end
        wait_res(got);
        e = sbq.pop_front();
        n_cmp++;
        if (!got || o_diff !== e.d || o_borrow !== e.br) begin
            n_bad++;
            $display("FAIL bp_next: got %h/%b want %h/%b", o_diff, o_borrow, e.d, e.br);
        end
        handoff();
    endtask

    task automatic test_reset_mid();
        bit   ok;
        bit   got;
        logic busy;
        exp_t e;
        issue(8'hAA, 8'h55, ok, busy);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_diff !== '0 ||
            o_borrow !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got v=%b r=%b d=%h b=%b want 0/1/00/0",
                     o_valid, o_ready, o_diff, o_borrow);
        end
        issue(8'h20, 8'h01, ok, busy);
        wait_res(got);
        n_cmp++;
        if (!ok || !got || sbq.size() == 0) begin
            n_bad++;
            $display("FAIL mid_next_done: got ok=%b got=%b want 1/1", ok, got);
            return;
        end
        e = sbq.pop_front();
        n_cmp++;
        if (o_diff !== e.d || o_borrow !== e.br) begin
            n_bad++;
            $display("FAIL mid_next: got %h/%b want %h/%b", o_diff, o_borrow, e.d, e.br);
        end
        handoff();
    endtask

    task automatic test_back_to_back();
        bit dup;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    bit   ok;
                    logic busy;
                    issue(WIDTH'($urandom), WIDTH'($urandom), ok, busy);
                    n_cmp++;
                    if (!ok || busy !== 1'b0) begin
                        n_bad++;
                        $display("FAIL b2b_accept[%0d]: got ok=%b busy=%b want 1/0",
                                 i, ok, busy);
                    end
                end
            end
            begin
                for (int n = 0; n < 16; n++) begin
                    bit   got;
                    exp_t e;
                    got = 1'b0;
                    for (int k = 0; k < 400; k++) begin
                        @(negedge clk);
                        i_ready = 1'($urandom_range(0, 1));
                        if (o_valid && i_ready) begin
                            got = 1'b1;
                            break;
                        end
                    end
                    n_cmp++;
                    if (!got || sbq.size() == 0) begin
                        n_bad++;
                        $display("FAIL b2b_recv[%0d]: got got=%b q=%0d want 1/>0",
                                 n, got, sbq.size());
                        break;
                    end
                    e = sbq.pop_front();
                    n_cmp++;
                    if (o_diff !== e.d || o_borrow !== e.br) begin
                        n_bad++;
                        $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b",
                                 n, o_diff, o_borrow, e.d, e.br);
                    end
                    @(posedge clk);
                    #1;
                    i_ready = 1'b0;
                end
            end
        join
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_leftover: got %0d want 0", sbq.size());
        end
        dup = 1'b0;
        i_ready = 1'b1;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (o_valid) dup = 1'b1;
        end
        i_ready = 1'b0;
        n_cmp++;
        if (dup) begin
            n_bad++;
            $display("FAIL b2b_duplicate: got extra o_valid want none");
        end
    endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    task automatic test_overflow();
        logic [WIDTH-1:0] ta[3] = '{8'h80, 8'h7F, 8'h05};
        logic [WIDTH-1:0] tb[3] = '{8'h01, 8'hFF, 8'h03};
        for (int i = 0; i < 3; i++) begin
            bit   ok;
            bit   got;
            logic busy;
            exp_t e;
            issue(ta[i], tb[i], ok, busy);
            wait_res(got);
            n_cmp++;
            if (!ok || !got || sbq.size() == 0) begin
                n_bad++;
                $display("FAIL ovf_done[%0d]: got ok=%b got=%b want 1/1", i, ok, got);
                continue;
            end
            e = sbq.pop_front();
            n_cmp++;
            if (o_diff !== e.d || o_overflow !== e.ov) begin
                n_bad++;
                $display("FAIL ovf_result[%0d]: got %h/%b want %h/%b",
                         i, o_diff, o_overflow, e.d, e.ov);
            end
            handoff();
        end
    endtask
`endif

    initial begin
        rst          = 1'b1;
        i_valid      = 1'b0;
        i_ready      = 1'b0;
        i_minuend    = '0;
        i_subtrahend = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        test_overflow();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
